// File: rtl/nl_outport_vc_scheduler_pkg.sv
// Shared types for the output-port VC scheduler: port vector type, VC state
// encoding and a one-hot test used to filter malformed route requests.
package nl_outport_vc_scheduler_pkg;

    localparam int NL_NP        = 7;
    localparam int NL_NV        = 2;
    localparam int NL_BUF_DEPTH = 4;

    // One bit per router output port; a well-formed route has exactly one bit set.
    typedef logic [NL_NP-1:0] output_port_t;

    // Life cycle of an output VC: FREE (allocatable), ACTIVE (owned by a
    // packet), DRAIN (tail gone, waiting for downstream credits to return).
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } vc_state_t;

    function automatic logic port_is_onehot(input output_port_t op);
        int n;
        n = 0;
        for (int b = 0; b < NL_NP; b++) begin
            n += int'(op[b]);
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/nl_outport_vc_scheduler_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant starting the search at a
// registered pointer; the pointer moves past the winner only when the caller
// confirms the grant was used (advance).
module nl_rr_arb #(
    parameter int SIZE = 14
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] req,
    input  logic            advance,
    output logic [SIZE-1:0] gnt
);

    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          found;
    int            idx;

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        gnt     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int k = 0; k < SIZE; k++) begin
            idx  = (int'(ptr) + k) % SIZE;
            cand = IW'(idx);
            if (!found && req[cand]) begin
                found      = 1'b1;
                gnt[cand]  = 1'b1;
                win_idx    = cand;
            end
        end
    end

    // Pointer moves to the slot after a confirmed winner, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (win_idx == IW'(SIZE-1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/nl_outport_vc_scheduler.sv
// Output-port VC allocator with per-output-VC credit tracking.
// Handshake: vc_req[i][j] is a level request; vc_grant[i][j] pulses for one
// cycle in the same cycle the request wins, with granted_vc naming the output
// VC. The requester must drop vc_req the cycle after the grant; a request
// still high then is a fresh request for another output VC.
module nl_outport_vc_scheduler
    import nl_outport_vc_scheduler_pkg::*;
#(
    parameter int NP        = NL_NP,
    parameter int NV        = NL_NV,
    parameter int BUF_DEPTH = NL_BUF_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vc_req       [NP][NV],
    input  output_port_t output_port  [NP][NV],
    output logic         vc_grant     [NP][NV],
    output logic [NV-1:0] granted_vc  [NP][NV],
    input  logic         flit_sent    [NP][NV],
    input  logic         tail_sent    [NP][NV],
    input  logic         credit_in    [NP][NV],
    output logic         credit_avail [NP][NV],
    output logic         outvc_free   [NP][NV],
    output logic         credit_err,
    output vc_state_t    state_dbg    [NP][NV]
);

    localparam int NR = NP * NV;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BUF_DEPTH);

    logic [NR-1:0] elig     [NP];
    logic [NR-1:0] arb_gnt  [NP];
    logic [NV-1:0] free_vec [NP];
    logic [NV-1:0] low_free [NP];
    logic          grant_ok [NP];
    logic [NR-1:0] err_vec;

    for (genvar p = 0; p < NP; p++) begin : g_port
        // A requester competes for port p only with a clean one-hot route to p.
        for (genvar r = 0; r < NR; r++) begin : g_elig
            assign elig[p][r] = vc_req[r/NV][r%NV] && output_port[r/NV][r%NV][p]
                                && port_is_onehot(output_port[r/NV][r%NV]);
        end

        // Lowest-numbered FREE VC is the one handed out.
        assign low_free[p] = free_vec[p] & (~free_vec[p] + 1'b1);
        assign grant_ok[p] = rst_n && (|free_vec[p]) && (|elig[p]);

        nl_rr_arb #(.SIZE(NR)) u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (elig[p]),
            .advance (grant_ok[p]),
            .gnt     (arb_gnt[p])
        );

        for (genvar v = 0; v < NV; v++) begin : g_vc
            vc_state_t     state_q, state_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          bad_d;
            logic          alloc;

            assign alloc = grant_ok[p] && low_free[p][v];

            // Credit counter update; out-of-range moves saturate and flag an error.
            always_comb begin
                cnt_d = cnt_q;
                bad_d = 1'b0;
                if (flit_sent[p][v] && !credit_in[p][v]) begin
                    if (cnt_q == '0) bad_d = 1'b1;
                    else             cnt_d = cnt_q - 1'b1;
                end else if (credit_in[p][v] && !flit_sent[p][v]) begin
                    if (cnt_q == CNT_FULL) bad_d = 1'b1;
                    else                   cnt_d = cnt_q + 1'b1;
                end
                if (flit_sent[p][v] && state_q == FREE) bad_d = 1'b1;
            end

            // Next state: a VC frees only once every downstream slot is back.
            always_comb begin
                state_d = state_q;
                case (state_q)
                    FREE:    if (alloc) state_d = ACTIVE;
                    ACTIVE:  if (flit_sent[p][v] && tail_sent[p][v])
                                 state_d = (cnt_d == CNT_FULL) ? FREE : DRAIN;
                    DRAIN:   if (cnt_d == CNT_FULL) state_d = FREE;
                    default: state_d = FREE;
                endcase
            end

            // State and credit registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= FREE;
                    cnt_q   <= CNT_FULL;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign free_vec[p][v]     = (state_q == FREE);
            assign err_vec[p*NV+v]    = bad_d;
            assign credit_avail[p][v] = (cnt_q != '0);
            assign outvc_free[p][v]   = (state_q == FREE);
            assign state_dbg[p][v]    = state_q;
        end
    end

    // Route each port's winner back to its requester; routes are one-hot so
    // at most one port can grant a given requester.
    for (genvar i = 0; i < NP; i++) begin : g_req_i
        for (genvar j = 0; j < NV; j++) begin : g_req_j
            always_comb begin
                vc_grant[i][j]   = 1'b0;
                granted_vc[i][j] = '0;
                for (int p = 0; p < NP; p++) begin
                    if (grant_ok[p] && arb_gnt[p][i*NV+j]) begin
                        vc_grant[i][j]   = 1'b1;
                        granted_vc[i][j] = low_free[p];
                    end
                end
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          credit_err <= 1'b0;
        else if (|err_vec)   credit_err <= 1'b1;
    end

endmodule

// File: tb/tb_nl_outport_vc_scheduler.sv
// Bench for nl_outport_vc_scheduler: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural allocator/credit model.
module tb_nl_outport_vc_scheduler;
    import nl_outport_vc_scheduler_pkg::*;

    localparam int NP  = 7;
    localparam int NV  = 2;
    localparam int BUF = 4;
    localparam int N   = NP * NV;
    localparam int M_FREE   = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_DRAIN  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vc_req       [NP][NV];
    output_port_t  output_port  [NP][NV];
    logic          vc_grant     [NP][NV];
    logic [NV-1:0] granted_vc   [NP][NV];
    logic          flit_sent    [NP][NV];
    logic          tail_sent    [NP][NV];
    logic          credit_in    [NP][NV];
    logic          credit_avail [NP][NV];
    logic          outvc_free   [NP][NV];
    logic          credit_err;
    vc_state_t     state_dbg    [NP][NV];

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: per-VC state/credits, per-port pointer, sticky error.
    int m_st  [NP][NV];
    int m_cnt [NP][NV];
    int m_ptr [NP];
    int m_win [NP];
    int m_win_vc [NP];
    bit m_err;

    nl_outport_vc_scheduler #(.NP(NP), .NV(NV), .BUF_DEPTH(BUF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vc_req       (vc_req),
        .output_port  (output_port),
        .vc_grant     (vc_grant),
        .granted_vc   (granted_vc),
        .flit_sent    (flit_sent),
        .tail_sent    (tail_sent),
        .credit_in    (credit_in),
        .credit_avail (credit_avail),
        .outvc_free   (outvc_free),
        .credit_err   (credit_err),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NP; i++) begin
            for (int j = 0; j < NV; j++) begin
                vc_req[i][j]      = 1'b0;
                output_port[i][j] = '0;
                flit_sent[i][j]   = 1'b0;
                tail_sent[i][j]   = 1'b0;
                credit_in[i][j]   = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_ptr[p] = 0;
            for (int v = 0; v < NV; v++) begin
                m_st[p][v]  = M_FREE;
                m_cnt[p][v] = BUF;
            end
        end
        m_err = 1'b0;
    endtask

    // Model the grants of the current cycle and compare every DUT output.
    task automatic eval_compare();
        logic [63:0] eg, ag, egv, agv, eca, aca, efr, afr, est, ast;
        vc_state_t es;
        int r;
        #1;
        eg = '0; ag = '0; egv = '0; agv = '0; eca = '0; aca = '0;
        efr = '0; afr = '0; est = '0; ast = '0;
        for (int p = 0; p < NP; p++) begin
            m_win[p]    = -1;
            m_win_vc[p] = -1;
            if (rst_n) begin
                for (int v = 0; v < NV; v++)
                    if (m_win_vc[p] < 0 && m_st[p][v] == M_FREE) m_win_vc[p] = v;
                if (m_win_vc[p] >= 0) begin
                    for (int k = 0; k < N; k++) begin
                        r = (m_ptr[p] + k) % N;
                        if (m_win[p] < 0 && vc_req[r/NV][r%NV] &&
                            int'(output_port[r/NV][r%NV]) == (1 << p))
                            m_win[p] = r;
                    end
                end
            end
            if (m_win[p] >= 0) begin
                eg[m_win[p]] = 1'b1;
                egv[m_win[p]*NV + m_win_vc[p]] = 1'b1;
            end
        end
        for (int i = 0; i < NP; i++) begin
            for (int j = 0; j < NV; j++) begin
                r = i*NV + j;
                ag[r] = vc_grant[i][j];
                if (eg[r]) for (int v = 0; v < NV; v++) agv[r*NV+v] = granted_vc[i][j][v];
                eca[r] = (m_cnt[i][j] != 0);
                aca[r] = credit_avail[i][j];
                efr[r] = (m_st[i][j] == M_FREE);
                afr[r] = outvc_free[i][j];
                es = (m_st[i][j] == M_FREE) ? FREE : (m_st[i][j] == M_ACTIVE) ? ACTIVE : DRAIN;
                est[2*r +: 2] = es;
                ast[2*r +: 2] = state_dbg[i][j];
            end
        end
        check("vc_grant", ag, eg);
        check("granted_vc", agv, egv);
        check("credit_avail", aca, eca);
        check("outvc_free", afr, efr);
        check("credit_err", 64'(credit_err), 64'(m_err));
        check("vc_state", ast, est);
    endtask

    // Apply the clock edge to the model using this cycle's inputs and grants.
    task automatic model_step();
        int n;
        bit f, c, t, g;
        for (int p = 0; p < NP; p++) begin
            for (int v = 0; v < NV; v++) begin
                f = flit_sent[p][v]; c = credit_in[p][v]; t = tail_sent[p][v];
                g = (m_win[p] >= 0) && (m_win_vc[p] == v);
                n = m_cnt[p][v];
                if (f && !c) begin
                    if (n == 0) m_err = 1'b1; else n = n - 1;
                end else if (c && !f) begin
                    if (n == BUF) m_err = 1'b1; else n = n + 1;
                end
                if (f && m_st[p][v] == M_FREE) m_err = 1'b1;
                if (m_st[p][v] == M_FREE) begin
                    if (g) m_st[p][v] = M_ACTIVE;
                end else if (m_st[p][v] == M_ACTIVE) begin
                    if (f && t) m_st[p][v] = (n == BUF) ? M_FREE : M_DRAIN;
                end else begin
                    if (n == BUF) m_st[p][v] = M_FREE;
                end
                m_cnt[p][v] = n;
            end
            if (m_win[p] >= 0) m_ptr[p] = (m_win[p] + 1) % N;
        end
    endtask

    task automatic advance();
        if (rst_n) model_step();
        @(posedge clk);
        @(negedge clk);
        if (!rst_n) model_reset();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        model_reset();
        eval_compare();
        advance();
        advance();
        rst_n = 1'b1;
    endtask

    int exp_rr [8] = '{0, 3, 6, 11, 0, 3, 6, 11};
    int got;
    logic [63:0] allfree;

    initial begin
        clear_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        do_reset();
        check("reset_err", 64'(credit_err), 64'd0);

        // Single request to port 4 is granted VC0 in the request cycle.
        vc_req[2][0] = 1'b1; output_port[2][0] = 7'b0010000;
        eval_compare();
        check("s1_grant", 64'(vc_grant[2][0]), 64'd1);
        check("s1_vc", 64'(granted_vc[2][0]), 64'd1);
        advance();
        vc_req[2][0] = 1'b0;
        eval_compare();
        check("s1_busy", 64'(outvc_free[4][0]), 64'd0);
        advance();

        // Three requesters to port 1: third waits for a drained VC.
        do_reset();
        vc_req[0][0] = 1; vc_req[1][0] = 1; vc_req[2][1] = 1;
        output_port[0][0] = 7'b0000010; output_port[1][0] = 7'b0000010; output_port[2][1] = 7'b0000010;
        eval_compare();
        check("s2_g0", 64'(vc_grant[0][0]), 64'd1);
        check("s2_g0_vc", 64'(granted_vc[0][0]), 64'd1);
        advance();
        vc_req[0][0] = 0;
        eval_compare();
        check("s2_g1", 64'(vc_grant[1][0]), 64'd1);
        check("s2_g1_vc", 64'(granted_vc[1][0]), 64'd2);
        advance();
        vc_req[1][0] = 0;
        flit_sent[1][0] = 1; tail_sent[1][0] = 1;
        eval_compare();
        check("s2_held", 64'(vc_grant[2][1]), 64'd0);
        advance();
        flit_sent[1][0] = 0; tail_sent[1][0] = 0;
        credit_in[1][0] = 1;
        eval_compare();
        check("s2_drain", 64'(state_dbg[1][0]), 64'(DRAIN));
        check("s2_held2", 64'(vc_grant[2][1]), 64'd0);
        advance();
        credit_in[1][0] = 0;
        eval_compare();
        check("s2_freed", 64'(outvc_free[1][0]), 64'd1);
        check("s2_g2", 64'(vc_grant[2][1]), 64'd1);
        check("s2_g2_vc", 64'(granted_vc[2][1]), 64'd1);
        advance();

        // Four persistent requesters to port 0 with VCs recycled every cycle.
        do_reset();
        vc_req[0][0] = 1; vc_req[1][1] = 1; vc_req[3][0] = 1; vc_req[5][1] = 1;
        output_port[0][0] = 7'b1; output_port[1][1] = 7'b1; output_port[3][0] = 7'b1; output_port[5][1] = 7'b1;
        for (int c = 0; c < 8; c++) begin
            for (int v = 0; v < NV; v++) begin
                flit_sent[0][v] = (m_st[0][v] == M_ACTIVE);
                tail_sent[0][v] = (m_st[0][v] == M_ACTIVE);
                credit_in[0][v] = (m_st[0][v] == M_ACTIVE);
            end
            eval_compare();
            got = -1;
            if (vc_grant[0][0]) got = 0;
            if (vc_grant[1][1]) got = 3;
            if (vc_grant[3][0]) got = 6;
            if (vc_grant[5][1]) got = 11;
            check("rr_order", 64'(got), 64'(exp_rr[c]));
            advance();
        end

        // Credit accounting on port 3.
        do_reset();
        vc_req[0][0] = 1; vc_req[0][1] = 1;
        output_port[0][0] = 7'b0001000; output_port[0][1] = 7'b0001000;
        eval_compare();
        check("s4_g0_vc", 64'(granted_vc[0][0]), 64'd1);
        advance();
        vc_req[0][0] = 0;
        eval_compare();
        check("s4_g1_vc", 64'(granted_vc[0][1]), 64'd2);
        advance();
        clear_inputs();
        for (int c = 0; c < 2; c++) begin
            flit_sent[3][0] = 1; eval_compare(); advance();
        end
        credit_in[3][0] = 1; eval_compare(); advance();
        credit_in[3][0] = 0; eval_compare(); advance();
        flit_sent[3][0] = 0; eval_compare();
        check("hold_cnt1", 64'(credit_avail[3][0]), 64'd1);
        flit_sent[3][0] = 1; eval_compare(); advance();
        flit_sent[3][0] = 0; eval_compare();
        check("hold_cnt0", 64'(credit_avail[3][0]), 64'd0);
        check("no_err_yet", 64'(credit_err), 64'd0);
        for (int c = 0; c < 4; c++) begin
            credit_in[3][0] = 1; eval_compare(); advance();
        end
        credit_in[3][0] = 1; flit_sent[3][0] = 1; tail_sent[3][0] = 1;
        eval_compare(); advance();
        clear_inputs(); eval_compare();
        check("tail_full_free", 64'(outvc_free[3][0]), 64'd1);
        for (int c = 0; c < 4; c++) begin
            flit_sent[3][1] = 1; eval_compare(); advance();
        end
        flit_sent[3][1] = 0; eval_compare();
        check("vc31_empty", 64'(credit_avail[3][1]), 64'd0);
        check("vc31_no_err", 64'(credit_err), 64'd0);
        flit_sent[3][1] = 1; eval_compare(); advance();
        flit_sent[3][1] = 0; eval_compare();
        check("underflow_err", 64'(credit_err), 64'd1);
        check("underflow_hold", 64'(credit_avail[3][1]), 64'd0);
        credit_in[3][1] = 1; eval_compare(); advance();
        credit_in[3][1] = 0; eval_compare();
        check("held_at_zero", 64'(credit_avail[3][1]), 64'd1);
        advance();

        // Overflow and flit on a FREE VC.
        do_reset();
        credit_in[5][0] = 1; eval_compare(); advance();
        credit_in[5][0] = 0; eval_compare();
        check("overflow_err", 64'(credit_err), 64'd1);
        do_reset();
        flit_sent[6][1] = 1; eval_compare(); advance();
        flit_sent[6][1] = 0; eval_compare();
        check("free_flit_err", 64'(credit_err), 64'd1);
        check("free_flit_state", 64'(outvc_free[6][1]), 64'd1);
        advance();

        // Asynchronous reset while a VC is ACTIVE.
        do_reset();
        vc_req[2][0] = 1; output_port[2][0] = 7'b1000000;
        eval_compare(); advance();
        eval_compare();
        check("pre_reset_busy", 64'(outvc_free[6][0]), 64'd0);
        #2;
        rst_n = 1'b0;
        model_reset();
        eval_compare();
        allfree = '0;
        for (int i = 0; i < NP; i++)
            for (int j = 0; j < NV; j++) allfree[i*NV+j] = outvc_free[i][j];
        check("async_free", allfree, 64'h3fff);
        check("async_no_grant", 64'(vc_grant[2][0]), 64'd0);
        advance();
        rst_n = 1'b1;
        clear_inputs();

        // Randomized traffic with a reset in the middle.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                rst_n = 1'b0;
                model_reset();
            end
            if (c == 303) rst_n = 1'b1;
            for (int i = 0; i < NP; i++) begin
                for (int j = 0; j < NV; j++) begin
                    int sel;
                    vc_req[i][j] = ($urandom_range(0, 3) == 0);
                    sel = $urandom_range(0, 9);
                    if (sel == 0)      output_port[i][j] = '0;
                    else if (sel == 1) output_port[i][j] = output_port_t'($urandom);
                    else               output_port[i][j] = output_port_t'(1 << $urandom_range(0, NP-1));
                    flit_sent[i][j] = (m_st[i][j] == M_ACTIVE) && (m_cnt[i][j] > 0) && ($urandom_range(0, 1) == 1);
                    tail_sent[i][j] = flit_sent[i][j] && ($urandom_range(0, 3) == 0);
                    credit_in[i][j] = (m_cnt[i][j] < BUF) && ($urandom_range(0, 2) == 0);
                end
            end
            eval_compare();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
